// File: rtl/score_pkg.sv
// Shared types and helpers for the high score tracker: BCD score layout,
// tracker states and digit validation.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hundreds;
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd_score_t;

    typedef enum logic [2:0] {
        PLAY    = 3'd0,
        CAPTURE = 3'd1,
        COMPARE = 3'd2,
        REC     = 3'd3,
        OVER    = 3'd4
    } tracker_state_t;

    localparam bcd_score_t BCD_ZERO = '{hundreds: 4'd0, tens: 4'd0, units: 4'd0};

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= 4'd9);
    endfunction

    // A single bad digit invalidates the whole score, so it reads as 000.
    function automatic bcd_score_t bcd_sanitise(input bcd_score_t score);
        if (bcd_valid(score.hundreds) && bcd_valid(score.tens) && bcd_valid(score.units)) begin
            return score;
        end else begin
            return BCD_ZERO;
        end
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running cycle divider: emits a one-cycle tick every TICKS enabled
// cycles; clear forces the count back to zero.
module tick_divider #(
    parameter int TICKS = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] count_r;

    // Cycle counter wrapping at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = en & ~clear & (count_r == LAST);

endmodule

// File: rtl/high_score_tracker.sv
// Session high-score tracker: detects game-over, latches the final score,
// keeps the best score and drives the score display mux.
module high_score_tracker
    import score_pkg::*;
#(
    parameter int BLINK_TICKS = 12,
    parameter int ALT_TICKS   = 48
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       death,
    input  logic       outofbounddeath,
    input  logic [3:0] hundredsDigit,
    input  logic [3:0] tensDigit,
    input  logic [3:0] unitsDigit,
    input  logic       clearBest,
    output logic [3:0] bestHundreds,
    output logic [3:0] bestTens,
    output logic [3:0] bestUnits,
    output logic       newRecord,
    output logic [3:0] dispHundreds,
    output logic [3:0] dispTens,
    output logic [3:0] dispUnits,
    output logic       dispBlank
);

    tracker_state_t state_r;
    bcd_score_t     final_r;
    bcd_score_t     best_r;
    bcd_score_t     disp_r;
    logic           new_record_r;
    logic           blank_r;
    logic           show_best_r;
    logic           over_q_r;

    bcd_score_t     live_s;
    bcd_score_t     best_kept_s;
    logic [11:0]    final_flat_s;
    logic [11:0]    best_flat_s;
    logic           over_s;
    logic           rise_s;
    logic           is_record_s;
    logic           show_next_s;
    logic           blink_tick_s;
    logic           alt_tick_s;
    logic           in_rec_s;
    logic           in_over_s;

    // Input conditioning and datapath helpers.
    always_comb begin
        live_s       = bcd_sanitise('{hundreds: hundredsDigit, tens: tensDigit, units: unitsDigit});
        over_s       = death | outofbounddeath;
        rise_s       = over_s & ~over_q_r;
        best_kept_s  = clearBest ? BCD_ZERO : best_r;
        final_flat_s = final_r;
        best_flat_s  = best_r;
        is_record_s  = (final_flat_s > best_flat_s);
        show_next_s  = show_best_r ^ alt_tick_s;
        in_rec_s     = (state_r == REC);
        in_over_s    = (state_r == OVER);
    end

    tick_divider #(.TICKS(BLINK_TICKS)) u_blink (
        .clk   (Clock),
        .rst_n (Reset_n),
        .en    (in_rec_s),
        .clear (~in_rec_s),
        .tick  (blink_tick_s)
    );

    tick_divider #(.TICKS(ALT_TICKS)) u_alt (
        .clk   (Clock),
        .rst_n (Reset_n),
        .en    (in_over_s),
        .clear (~in_over_s),
        .tick  (alt_tick_s)
    );

    // Tracker state machine with registered display and status outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= PLAY;
            final_r      <= BCD_ZERO;
            best_r       <= BCD_ZERO;
            disp_r       <= BCD_ZERO;
            new_record_r <= 1'b0;
            blank_r      <= 1'b0;
            show_best_r  <= 1'b0;
            over_q_r     <= 1'b0;
        end else begin
            over_q_r <= over_s;
            best_r   <= best_kept_s;
            case (state_r)
                PLAY: begin
                    disp_r <= live_s;
                    if (rise_s) begin
                        state_r <= CAPTURE;
                    end else begin
                        state_r <= PLAY;
                    end
                end
                CAPTURE: begin
                    final_r <= live_s;
                    disp_r  <= live_s;
                    state_r <= COMPARE;
                end
                COMPARE: begin
                    // Compared against the pre-clear best; a clear still wins the write.
                    disp_r      <= final_r;
                    blank_r     <= 1'b0;
                    show_best_r <= 1'b0;
                    if (is_record_s) begin
                        best_r       <= clearBest ? BCD_ZERO : final_r;
                        new_record_r <= 1'b1;
                        state_r      <= REC;
                    end else begin
                        state_r <= OVER;
                    end
                end
                REC: begin
                    if (!over_s) begin
                        state_r      <= PLAY;
                        new_record_r <= 1'b0;
                        blank_r      <= 1'b0;
                        show_best_r  <= 1'b0;
                        disp_r       <= live_s;
                    end else begin
                        disp_r  <= final_r;
                        blank_r <= blank_r ^ blink_tick_s;
                    end
                end
                OVER: begin
                    if (!over_s) begin
                        state_r      <= PLAY;
                        new_record_r <= 1'b0;
                        blank_r      <= 1'b0;
                        show_best_r  <= 1'b0;
                        disp_r       <= live_s;
                    end else begin
                        show_best_r <= show_next_s;
                        disp_r      <= show_next_s ? best_kept_s : final_r;
                    end
                end
                default: begin
                    state_r      <= PLAY;
                    new_record_r <= 1'b0;
                    blank_r      <= 1'b0;
                    show_best_r  <= 1'b0;
                    disp_r       <= live_s;
                end
            endcase
        end
    end

    assign bestHundreds = best_r.hundreds;
    assign bestTens     = best_r.tens;
    assign bestUnits    = best_r.units;
    assign newRecord    = new_record_r;
    assign dispHundreds = disp_r.hundreds;
    assign dispTens     = disp_r.tens;
    assign dispUnits    = disp_r.units;
    assign dispBlank    = blank_r;

endmodule

// File: tb/tb_high_score_tracker.sv
// Self-checking bench for high_score_tracker: directed scenarios with literal
// expectations plus randomized play checked against a behavioural model.
module tb_high_score_tracker;

    logic       Clock;
    logic       Reset_n;
    logic       death;
    logic       outofbounddeath;
    logic [3:0] hundredsDigit;
    logic [3:0] tensDigit;
    logic [3:0] unitsDigit;
    logic       clearBest;
    logic [3:0] bestHundreds, bestTens, bestUnits;
    logic       newRecord;
    logic [3:0] dispHundreds, dispTens, dispUnits;
    logic       dispBlank;

    int n_checks = 0;
    int n_errors = 0;

    high_score_tracker #(.BLINK_TICKS(12), .ALT_TICKS(48)) dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .death           (death),
        .outofbounddeath (outofbounddeath),
        .hundredsDigit   (hundredsDigit),
        .tensDigit       (tensDigit),
        .unitsDigit      (unitsDigit),
        .clearBest       (clearBest),
        .bestHundreds    (bestHundreds),
        .bestTens        (bestTens),
        .bestUnits       (bestUnits),
        .newRecord       (newRecord),
        .dispHundreds    (dispHundreds),
        .dispTens        (dispTens),
        .dispUnits       (dispUnits),
        .dispBlank       (dispBlank)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Model: phase 0 playing, 1 capturing, 2 comparing, 3 showing the result.
    int          m_phase;
    bit          m_is_rec;
    int          m_k;
    logic [11:0] m_final, m_best, m_disp;
    logic        m_nr, m_blank, m_overq;

    function automatic logic [11:0] san(input logic [11:0] s);
        if (s[11:8] > 4'd9 || s[7:4] > 4'd9 || s[3:0] > 4'd9) return 12'h000;
        else return s;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_is_rec = 1'b0; m_k = 0;
        m_final = 12'h000; m_best = 12'h000; m_disp = 12'h000;
        m_nr = 1'b0; m_blank = 1'b0; m_overq = 1'b0;
    endtask

    task automatic model_update();
        logic        over;
        logic [11:0] sv;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        over = death | outofbounddeath;
        sv   = san({hundredsDigit, tensDigit, unitsDigit});
        case (m_phase)
            0: begin
                m_disp = sv;
                if (over && !m_overq) m_phase = 1;
            end
            1: begin
                m_final = sv;
                m_disp  = sv;
                m_phase = 2;
            end
            2: begin
                m_disp   = m_final;
                m_k      = 0;
                m_is_rec = (m_final > m_best);
                if (m_is_rec) begin
                    m_nr   = 1'b1;
                    m_best = m_final;
                end
                m_phase = 3;
            end
            default: begin
                if (!over) begin
                    m_phase = 0;
                    m_nr    = 1'b0;
                    m_disp  = sv;
                    m_k     = 0;
                end else begin
                    m_k = m_k + 1;
                    if (!m_is_rec && ((m_k / 48) % 2 == 1)) m_disp = clearBest ? 12'h000 : m_best;
                    else m_disp = m_final;
                end
            end
        endcase
        m_blank = (m_phase == 3 && m_is_rec) ? 1'(((m_k / 12) % 2)) : 1'b0;
        if (clearBest) m_best = 12'h000;
        m_overq = over;
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin
        chk("best", {bestHundreds, bestTens, bestUnits}, m_best);
        chk("newRecord", {11'd0, newRecord}, {11'd0, m_nr});
        chk("disp", {dispHundreds, dispTens, dispUnits}, m_disp);
        chk("dispBlank", {11'd0, dispBlank}, {11'd0, m_blank});
    end

    task automatic step();
        @(posedge Clock);
        model_update();
        @(negedge Clock);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_live(input logic [11:0] s);
        hundredsDigit = s[11:8];
        tensDigit     = s[7:4];
        unitsDigit    = s[3:0];
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
        else return 4'($urandom_range(0, 9));
    endfunction

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 19) == 0) death = ~death;
            if ($urandom_range(0, 29) == 0) outofbounddeath = ~outofbounddeath;
            clearBest = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                hundredsDigit = rand_digit();
                tensDigit     = rand_digit();
                unitsDigit    = rand_digit();
            end
            step();
        end
        clearBest = 1'b0;
    endtask

    logic [11:0] best_o, disp_o;
    assign best_o = {bestHundreds, bestTens, bestUnits};
    assign disp_o = {dispHundreds, dispTens, dispUnits};

    initial begin
        model_reset();
        Reset_n = 1'b0; death = 1'b0; outofbounddeath = 1'b0; clearBest = 1'b0;
        set_live(12'h00F);
        steps(2);
        chk("rst_best", best_o, 12'h000);
        chk("rst_newRecord", {11'd0, newRecord}, 12'h000);
        chk("rst_dispBlank", {11'd0, dispBlank}, 12'h000);
        chk("rst_disp", disp_o, 12'h000);

        // Invalid units digit right after reset with immediate death.
        Reset_n = 1'b1; death = 1'b1;
        steps(3);
        chk("bad_best", best_o, 12'h000);
        chk("bad_newRecord", {11'd0, newRecord}, 12'h000);
        chk("bad_disp", disp_o, 12'h000);
        death = 1'b0;
        step();

        // New record 005, blink at +12 and +24.
        set_live(12'h005);
        step();
        death = 1'b1;
        steps(2);
        chk("rec_best_before", best_o, 12'h000);
        step();
        chk("rec_best", best_o, 12'h005);
        chk("rec_newRecord", {11'd0, newRecord}, 12'h001);
        steps(11);
        chk("rec_blank_11", {11'd0, dispBlank}, 12'h000);
        step();
        chk("rec_blank_12", {11'd0, dispBlank}, 12'h001);
        chk("rec_disp", disp_o, 12'h005);
        steps(11);
        chk("rec_blank_23", {11'd0, dispBlank}, 12'h001);
        step();
        chk("rec_blank_24", {11'd0, dispBlank}, 12'h000);
        death = 1'b0;
        step();
        chk("rec_exit_newRecord", {11'd0, newRecord}, 12'h000);

        // Lower score 003 by out-of-bounds: final then best alternation.
        set_live(12'h003);
        outofbounddeath = 1'b1;
        steps(3);
        chk("over_best", best_o, 12'h005);
        chk("over_newRecord", {11'd0, newRecord}, 12'h000);
        chk("over_disp_0", disp_o, 12'h003);
        steps(47);
        chk("over_disp_47", disp_o, 12'h003);
        step();
        chk("over_disp_48", disp_o, 12'h005);
        outofbounddeath = 1'b0;
        step();

        // Equal score is not a record; display follows live after exit.
        set_live(12'h007);
        death = 1'b1;
        steps(3);
        chk("eq_setup_best", best_o, 12'h007);
        death = 1'b0;
        step();
        death = 1'b1;
        steps(3);
        chk("eq_newRecord", {11'd0, newRecord}, 12'h000);
        chk("eq_best", best_o, 12'h007);
        set_live(12'h042);
        death = 1'b0;
        step();
        chk("eq_exit_disp", disp_o, 12'h042);

        // Clear during COMPARE: record still flagged, best cleared.
        clearBest = 1'b1;
        step();
        clearBest = 1'b0;
        set_live(12'h004);
        death = 1'b1;
        steps(3);
        chk("clr_setup_best", best_o, 12'h004);
        death = 1'b0;
        step();
        set_live(12'h012);
        death = 1'b1;
        steps(2);
        clearBest = 1'b1;
        step();
        clearBest = 1'b0;
        chk("clr_best", best_o, 12'h000);
        chk("clr_newRecord", {11'd0, newRecord}, 12'h001);
        death = 1'b0;
        step();

        random_cycles(3000);

        // Asynchronous reset in the middle of REC.
        death = 1'b0; outofbounddeath = 1'b0;
        clearBest = 1'b1;
        step();
        clearBest = 1'b0;
        step();
        set_live(12'h999);
        death = 1'b1;
        steps(8);
        chk("arst_pre_newRecord", {11'd0, newRecord}, 12'h001);
        @(posedge Clock);
        model_update();
        #3;
        Reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_best", best_o, 12'h000);
        chk("arst_newRecord", {11'd0, newRecord}, 12'h000);
        chk("arst_dispBlank", {11'd0, dispBlank}, 12'h000);
        chk("arst_disp", disp_o, 12'h000);
        @(negedge Clock);
        steps(2);
        Reset_n = 1'b1;
        death = 1'b0;
        random_cycles(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/high_score_tracker.md
Name: high_score_tracker

Overview:
- Consumes the BCD score digits and the two death flags from the score counter.
- Holds the session best score and detects game-over.
- On game-over it latches the final score, compares it against the best, and records a new best when the final score is higher.
- Drives the score display mux: live score while playing; final/best alternation or new-record blink after game-over.

Parameters:
- BLINK_TICKS, 12, Clock cycles per blink half-period in REC state (0.5 s at 24 Hz).
- ALT_TICKS, 48, Clock cycles between final/best display swaps in OVER state (2 s at 24 Hz).

Ports:
- Clock  in  1  system clock; same clock as the score counter.
- Reset_n  in  1  asynchronous, active-low reset.
- death  in  1  collision death flag, level.
- outofbounddeath  in  1  out-of-bounds death flag, level.
- hundredsDigit  in  4  live score BCD hundreds.
- tensDigit  in  4  live score BCD tens.
- unitsDigit  in  4  live score BCD units.
- clearBest  in  1  synchronous, level-sampled; clears the best score.
- bestHundreds / bestTens / bestUnits  out  4 each  stored best score, BCD.
- newRecord  out  1  high from the COMPARE exit into REC until the next PLAY entry.
- dispHundreds / dispTens / dispUnits  out  4 each  digits to the 7-seg decoders.
- dispBlank  out  1  when high, decoders blank all digits.

Behaviour:
- over = death | outofbounddeath. over_q is a registered copy; rising edge = over & ~over_q.
- Reset (async, Reset_n=0):
  - state=PLAY; best=000; final=000; newRecord=0; dispBlank=0.
  - Both tick counters = 0; showBest=0; over_q=0.
- Digit sanitising:
  - Any input digit > 9 (e.g. upstream units = 4'hF right after reset) makes the whole live score read as 000.
  - This applies to both display and capture.
- State machine:
  - PLAY: disp = sanitised live digits. Rising edge of over -> CAPTURE.
  - CAPTURE (1 cycle): final <= sanitised live digits -> COMPARE.
  - COMPARE (1 cycle): compare {H,T,U} as a 12-bit unsigned value; valid BCD preserves ordering.
    - final > best: best <= final, newRecord <= 1 -> REC.
    - Otherwise -> OVER. Equal scores are not a record.
  - REC: disp = final.
    - dispBlank toggles every BLINK_TICKS cycles, starting at 0 on entry.
    - over = 0 -> PLAY.
  - OVER: disp = final when showBest=0, best when showBest=1.
    - showBest toggles every ALT_TICKS cycles, starting at 0 on entry.
    - over = 0 -> PLAY.
- PLAY entry: newRecord=0, dispBlank=0, showBest=0, tick counters=0.
- Latency:
  - best is updated 2 cycles after the over rising edge.
  - newRecord rises in the same cycle as the best update.
- Level-held over never retriggers capture; only a fresh rising edge after returning to PLAY does.
- over dropping while in CAPTURE or COMPARE: the sequence completes to REC/OVER, then exits to PLAY on the next cycle.
- clearBest=1:
  - best <= 000 in any state.
  - In the COMPARE cycle, clear wins over the update, and the comparison is against the pre-clear best.
  - newRecord is unaffected.
- Tick counters wrap to 0 at terminal count. Widths = $clog2 of the parameter.
- Reset asserted mid-sequence returns immediately to reset values, including best.

Decomposition:
- Shared package (score_pkg):
  - bcd_digit_t (4-bit) and bcd_score_t (struct of hundreds/tens/units).
  - Enum tracker_state_t {PLAY, CAPTURE, COMPARE, REC, OVER}.
  - Function bcd_valid() and constant BCD_ZERO.
- Sub-module: tick_divider (counter with TICKS parameter, enable, clear, 1-cycle tick pulse). Instantiated twice, once for blink and once for alternation.

Test Plan:
- Live 005 then death=1 held -> best=005 at edge+2, newRecord=1; dispBlank toggles at +12 and +24 cycles after REC entry.
- best=005, live 003, outofbounddeath=1 -> state OVER, best stays 005, newRecord=0; disp shows 003 for 48 cycles, then 005.
- best=007, live 007, death -> no record, OVER. Then death=0 -> PLAY and disp follows live digits next cycle.
- Inputs units=F after upstream reset, immediate death -> final=000, best stays 000, OVER; disp never shows F.
- clearBest=1 in the COMPARE cycle with final=012 > best=004 -> best=000, newRecord=1 -> REC.
- Reset_n pulsed low asynchronously mid-REC (not aligned to a Clock edge) -> all outputs at reset values immediately, state=PLAY, best=000.
